// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALU opcodes, TSC opcode/func
// values, branch kinds and the controller state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0101;
  localparam logic [3:0] ALU_ORR   = 4'b0110;
  localparam logic [3:0] ALU_PASSA = 4'b1000;
  localparam logic [3:0] ALU_NOT   = 4'b1001;
  localparam logic [3:0] ALU_SHR   = 4'b1011;
  localparam logic [3:0] ALU_TCP   = 4'b1100;
  localparam logic [3:0] ALU_SHL   = 4'b1101;
  localparam logic [3:0] ALU_LHI   = 4'b1111;

  localparam logic [3:0] OPC_BNE   = 4'd0;
  localparam logic [3:0] OPC_BEQ   = 4'd1;
  localparam logic [3:0] OPC_BGZ   = 4'd2;
  localparam logic [3:0] OPC_BLZ   = 4'd3;
  localparam logic [3:0] OPC_ADI   = 4'd4;
  localparam logic [3:0] OPC_ORI   = 4'd5;
  localparam logic [3:0] OPC_LHI   = 4'd6;
  localparam logic [3:0] OPC_RTYPE = 4'd15;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;

  typedef enum logic [1:0] {BR_NE, BR_EQ, BR_GZ, BR_LZ} br_kind_e;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational mapping from a decoded TSC instruction to ALU operands/opcode
// plus the flags the controller needs to interpret the ALU outputs.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       opcode_i,
  input  logic [5:0]       func_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic [7:0]       imm_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [3:0]       op_o,
  output logic             isBranch_o,
  output br_kind_e         brKind_o,
  output logic             ovfEn_o,
  output logic             illegal_o
);

  always_comb begin
    a_o        = rs_i;
    b_o        = rt_i;
    op_o       = ALU_PASSA;
    isBranch_o = 1'b0;
    brKind_o   = BR_NE;
    ovfEn_o    = 1'b0;
    illegal_o  = 1'b0;
    unique case (opcode_i)
      OPC_BNE, OPC_BEQ, OPC_BGZ, OPC_BLZ: begin
        op_o       = ALU_SUB;
        isBranch_o = 1'b1;
        ovfEn_o    = 1'b1;
        brKind_o   = br_kind_e'(opcode_i[1:0]);
        // Sign tests compare rs against zero.
        if (opcode_i == OPC_BGZ || opcode_i == OPC_BLZ) b_o = '0;
      end
      OPC_ADI: begin
        op_o    = ALU_ADD;
        b_o     = {{(WIDTH-8){imm_i[7]}}, imm_i};
        ovfEn_o = 1'b1;
      end
      OPC_ORI: begin
        op_o = ALU_ORR;
        b_o  = {{(WIDTH-8){1'b0}}, imm_i};
      end
      OPC_LHI: begin
        op_o = ALU_LHI;
        b_o  = {{(WIDTH-8){1'b0}}, imm_i};
      end
      OPC_RTYPE: begin
        unique case (func_i)
          FN_ADD: begin op_o = ALU_ADD; ovfEn_o = 1'b1; end
          FN_SUB: begin op_o = ALU_SUB; ovfEn_o = 1'b1; end
          FN_AND: op_o = ALU_AND;
          FN_ORR: op_o = ALU_ORR;
          FN_NOT: op_o = ALU_NOT;
          FN_TCP: op_o = ALU_TCP;
          FN_SHL: op_o = ALU_SHL;
          FN_SHR: op_o = ALU_SHR;
          default: begin
            a_o       = '0;
            b_o       = '0;
            illegal_o = 1'b1;
          end
        endcase
      end
      default: begin
        a_o       = '0;
        b_o       = '0;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded instruction to the external combinational ALU, captures
// its outputs after one settle cycle and hands the result back over valid/ready.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_opcode,
  input  logic [5:0]       req_func,
  input  logic [WIDTH-1:0] req_rs,
  input  logic [WIDTH-1:0] req_rt,
  input  logic [7:0]       req_imm,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [3:0]       alu_OP,
  input  logic [WIDTH-1:0] alu_C,
  input  logic             alu_Cout,
  input  logic             alu_bcond,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_taken,
  output logic             rsp_illegal,
  output logic             ovf_sticky,
  input  logic             clr_ovf,
  output logic [CNT_W-1:0] op_count
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] decA, decB;
  logic [3:0]       decOp;
  logic             decIsBranch, decOvfEn, decIllegal;
  br_kind_e         decBrKind;

  logic [WIDTH-1:0] aluA_q, aluB_q, rspData_q;
  logic [3:0]       aluOp_q;
  logic             isBranch_q, ovfEn_q, illegal_q;
  br_kind_e         brKind_q;
  logic             rspOvf_q, rspTaken_q, rspIllegal_q, ovfSticky_q;
  logic [CNT_W-1:0] opCount_q;
  logic             accept, capture, handoff, takenNow, ovfNow;

  alu_op_decode #(.WIDTH(WIDTH)) u_decode (
    .opcode_i   (req_opcode),
    .func_i     (req_func),
    .rs_i       (req_rs),
    .rt_i       (req_rt),
    .imm_i      (req_imm),
    .a_o        (decA),
    .b_o        (decB),
    .op_o       (decOp),
    .isBranch_o (decIsBranch),
    .brKind_o   (decBrKind),
    .ovfEn_o    (decOvfEn),
    .illegal_o  (decIllegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
  end

  assign accept  = (state_q == S_IDLE) && req_valid;
  assign capture = (state_q == S_EXEC);
  assign handoff = (state_q == S_RESP) && rsp_ready;
  assign ovfNow  = ovfEn_q & alu_Cout;

  always_comb begin
    takenNow = 1'b0;
    if (isBranch_q) begin
      unique case (brKind_q)
        BR_NE:   takenNow = alu_bcond;
        BR_EQ:   takenNow = ~alu_bcond;
        BR_GZ:   takenNow = alu_bcond & ~alu_C[WIDTH-1];
        BR_LZ:   takenNow = alu_C[WIDTH-1];
        default: takenNow = 1'b0;
      endcase
    end
  end

  // Operand/kind registers load on accept; response registers load on capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      aluA_q       <= '0;
      aluB_q       <= '0;
      aluOp_q      <= ALU_PASSA;
      isBranch_q   <= 1'b0;
      brKind_q     <= BR_NE;
      ovfEn_q      <= 1'b0;
      illegal_q    <= 1'b0;
      rspData_q    <= '0;
      rspOvf_q     <= 1'b0;
      rspTaken_q   <= 1'b0;
      rspIllegal_q <= 1'b0;
      ovfSticky_q  <= 1'b0;
      opCount_q    <= '0;
    end else begin
      if (accept) begin
        aluA_q     <= decA;
        aluB_q     <= decB;
        aluOp_q    <= decOp;
        isBranch_q <= decIsBranch;
        brKind_q   <= decBrKind;
        ovfEn_q    <= decOvfEn;
        illegal_q  <= decIllegal;
      end
      if (capture) begin
        rspData_q    <= illegal_q ? '0 : alu_C;
        rspOvf_q     <= ovfNow;
        rspTaken_q   <= takenNow;
        rspIllegal_q <= illegal_q;
      end
      if (capture && ovfNow) ovfSticky_q <= 1'b1;
      else if (clr_ovf)      ovfSticky_q <= 1'b0;
      if (handoff) opCount_q <= opCount_q + 1'b1;
    end
  end

  assign alu_A       = aluA_q;
  assign alu_B       = aluB_q;
  assign alu_OP      = aluOp_q;
  assign rsp_data    = rspData_q;
  assign rsp_ovf     = rspOvf_q;
  assign rsp_taken   = rspTaken_q;
  assign rsp_illegal = rspIllegal_q;
  assign ovf_sticky  = ovfSticky_q;
  assign op_count    = opCount_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus random
// instructions, checked against an instruction-level reference model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_opcode = '0;
  logic [5:0]  req_func = '0;
  logic [15:0] req_rs = '0, req_rt = '0;
  logic [7:0]  req_imm = '0;
  logic [15:0] alu_A, alu_B, alu_C;
  logic [3:0]  alu_OP;
  logic        alu_Cout, alu_bcond;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_ovf, rsp_taken, rsp_illegal, ovf_sticky;
  logic        clr_ovf = 1'b0;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;
  int modelCount = 0;
  bit modelSticky = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_func(req_func),
    .req_rs(req_rs), .req_rt(req_rt), .req_imm(req_imm),
    .alu_A(alu_A), .alu_B(alu_B), .alu_OP(alu_OP),
    .alu_C(alu_C), .alu_Cout(alu_Cout), .alu_bcond(alu_bcond),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .rsp_taken(rsp_taken),
    .rsp_illegal(rsp_illegal), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf),
    .op_count(op_count)
  );

  // Stand-in ALU; Cout and bcond are left live for every op so the controller's gating matters.
  logic [15:0] aluSum, aluDiff;
  always_comb begin
    aluSum  = alu_A + alu_B;
    aluDiff = alu_A - alu_B;
    alu_C   = alu_A;
    case (alu_OP)
      4'b0000: alu_C = aluSum;
      4'b0001: alu_C = aluDiff;
      4'b0101: alu_C = alu_A & alu_B;
      4'b0110: alu_C = alu_A | alu_B;
      4'b1001: alu_C = ~alu_A;
      4'b1011: alu_C = $signed(alu_A) >>> 1;
      4'b1100: alu_C = ~alu_A + 16'd1;
      4'b1101: alu_C = alu_A << 1;
      4'b1111: alu_C = {alu_B[7:0], 8'h00};
      default: alu_C = alu_A;
    endcase
    if (alu_OP == 4'b0001)
      alu_Cout = (alu_A[15] != alu_B[15]) && (aluDiff[15] != alu_A[15]);
    else
      alu_Cout = (alu_A[15] == alu_B[15]) && (aluSum[15] != alu_A[15]);
    alu_bcond = (aluDiff != 16'd0);
  end

  // Instruction-level reference: results from integer arithmetic on rs/rt/imm.
  task automatic model(input logic [3:0] opc, input logic [5:0] fn,
                       input logic [15:0] rs, input logic [15:0] rt, input logic [7:0] imm,
                       output logic [15:0] d, output logic ovf, output logic taken,
                       output logic ill, output logic [3:0] op,
                       output logic [15:0] a, output logic [15:0] b, output logic chkB);
    int sr, st, si, s;
    sr = $signed(rs); st = $signed(rt); si = $signed(imm);
    d = 16'h0; ovf = 0; taken = 0; ill = 0; op = 4'b1000; a = rs; b = rt; chkB = 1;
    if (opc <= 4'd3) begin
      op = 4'b0001;
      if (opc >= 4'd2) begin b = 16'h0; st = 0; end
      s = sr - st; d = 16'(s); ovf = (s > 32767) || (s < -32768);
      case (opc)
        4'd0: taken = (rs != rt);
        4'd1: taken = (rs == rt);
        4'd2: taken = (sr > 0);
        default: taken = (sr < 0);
      endcase
    end else if (opc == 4'd4) begin
      op = 4'b0000; b = 16'(si); s = sr + si; d = 16'(s); ovf = (s > 32767) || (s < -32768);
    end else if (opc == 4'd5) begin
      op = 4'b0110; b = 16'(int'(imm)); d = rs | b;
    end else if (opc == 4'd6) begin
      op = 4'b1111; b = 16'(int'(imm)); d = 16'(int'(imm) * 256);
    end else if (opc == 4'd15 && fn < 6'd8) begin
      case (fn)
        6'd0: begin op = 4'b0000; s = sr + st; d = 16'(s); ovf = (s > 32767) || (s < -32768); end
        6'd1: begin op = 4'b0001; s = sr - st; d = 16'(s); ovf = (s > 32767) || (s < -32768); end
        6'd2: begin op = 4'b0101; d = rs & rt; end
        6'd3: begin op = 4'b0110; d = rs | rt; end
        6'd4: begin op = 4'b1001; d = 16'(65535 - int'(rs)); chkB = 0; end
        6'd5: begin op = 4'b1100; d = 16'(-sr); chkB = 0; end
        6'd6: begin op = 4'b1101; d = 16'(int'(rs) * 2); chkB = 0; end
        default: begin op = 4'b1011; d = 16'((sr - (sr & 1)) / 2); chkB = 0; end
      endcase
    end else begin
      ill = 1; a = 16'h0; b = 16'h0;
    end
  endtask

  task automatic run_txn(input string tag, input logic [3:0] opc, input logic [5:0] fn,
                         input logic [15:0] rs, input logic [15:0] rt, input logic [7:0] imm,
                         input bit clr, input int hold);
    logic [15:0] eD, eA, eB;
    logic eOvf, eTaken, eIll, chkB;
    logic [3:0] eOp;
    model(opc, fn, rs, rt, imm, eD, eOvf, eTaken, eIll, eOp, eA, eB, chkB);
    req_opcode = opc; req_func = fn; req_rs = rs; req_rt = rt; req_imm = imm;
    req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s req_ready_idle: got %b expected 1", tag, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    clr_ovf = clr;
    checks += 4;
    if (alu_OP !== eOp) begin errors++; $display("[TB] FAIL %s alu_OP: got %h expected %h", tag, alu_OP, eOp); end
    if (alu_A !== eA) begin errors++; $display("[TB] FAIL %s alu_A: got %h expected %h", tag, alu_A, eA); end
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s rsp_valid_exec: got %b expected 0", tag, rsp_valid); end
    if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL %s req_ready_exec: got %b expected 0", tag, req_ready); end
    if (chkB) begin
      checks++;
      if (alu_B !== eB) begin errors++; $display("[TB] FAIL %s alu_B: got %h expected %h", tag, alu_B, eB); end
    end
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    if (eOvf) modelSticky = 1;
    else if (clr) modelSticky = 0;
    for (int i = 0; i <= hold; i++) begin
      checks += 8;
      if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL %s rsp_valid: got %b expected 1", tag, rsp_valid); end
      if (rsp_data !== eD) begin errors++; $display("[TB] FAIL %s rsp_data: got %h expected %h", tag, rsp_data, eD); end
      if (rsp_ovf !== eOvf) begin errors++; $display("[TB] FAIL %s rsp_ovf: got %b expected %b", tag, rsp_ovf, eOvf); end
      if (rsp_taken !== eTaken) begin errors++; $display("[TB] FAIL %s rsp_taken: got %b expected %b", tag, rsp_taken, eTaken); end
      if (rsp_illegal !== eIll) begin errors++; $display("[TB] FAIL %s rsp_illegal: got %b expected %b", tag, rsp_illegal, eIll); end
      if (ovf_sticky !== modelSticky) begin errors++; $display("[TB] FAIL %s ovf_sticky: got %b expected %b", tag, ovf_sticky, modelSticky); end
      if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL %s req_ready_resp: got %b expected 0", tag, req_ready); end
      if (op_count !== 16'(modelCount)) begin errors++; $display("[TB] FAIL %s op_count_held: got %0d expected %0d", tag, op_count, modelCount); end
      if (i < hold) begin @(posedge clk); #1; end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    modelCount++;
    checks += 3;
    if (op_count !== 16'(modelCount)) begin errors++; $display("[TB] FAIL %s op_count: got %0d expected %0d", tag, op_count, modelCount); end
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s req_ready_after: got %b expected 1", tag, req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s rsp_valid_after: got %b expected 0", tag, rsp_valid); end
  endtask

  task automatic check_reset_values(input string tag);
    checks += 11;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s req_ready: got %b expected 1", tag, req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s rsp_valid: got %b expected 0", tag, rsp_valid); end
    if (rsp_data !== 16'h0) begin errors++; $display("[TB] FAIL %s rsp_data: got %h expected 0000", tag, rsp_data); end
    if (rsp_ovf !== 1'b0) begin errors++; $display("[TB] FAIL %s rsp_ovf: got %b expected 0", tag, rsp_ovf); end
    if (rsp_taken !== 1'b0) begin errors++; $display("[TB] FAIL %s rsp_taken: got %b expected 0", tag, rsp_taken); end
    if (rsp_illegal !== 1'b0) begin errors++; $display("[TB] FAIL %s rsp_illegal: got %b expected 0", tag, rsp_illegal); end
    if (alu_A !== 16'h0) begin errors++; $display("[TB] FAIL %s alu_A: got %h expected 0000", tag, alu_A); end
    if (alu_B !== 16'h0) begin errors++; $display("[TB] FAIL %s alu_B: got %h expected 0000", tag, alu_B); end
    if (alu_OP !== 4'b1000) begin errors++; $display("[TB] FAIL %s alu_OP: got %h expected 8", tag, alu_OP); end
    if (ovf_sticky !== 1'b0) begin errors++; $display("[TB] FAIL %s ovf_sticky: got %b expected 0", tag, ovf_sticky); end
    if (op_count !== 16'h0) begin errors++; $display("[TB] FAIL %s op_count: got %0d expected 0", tag, op_count); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    modelCount = 0; modelSticky = 0;
    check_reset_values("reset");
  endtask

  task automatic test_add_overflow();
    run_txn("ADD", 4'd15, 6'd0, 16'h7FFF, 16'h0001, 8'h00, 0, 0);
  endtask

  task automatic test_immediates();
    run_txn("ADI", 4'd4, 6'd0, 16'h0010, 16'h1234, 8'hFE, 0, 0);
    run_txn("LHI", 4'd6, 6'd0, 16'h5555, 16'h0000, 8'hA5, 0, 0);
    run_txn("ORI", 4'd5, 6'd0, 16'h1200, 16'h0000, 8'h80, 0, 0);
  endtask

  task automatic test_branches();
    run_txn("BEQ", 4'd1, 6'd0, 16'h0005, 16'h0005, 8'h00, 0, 0);
    run_txn("BNE", 4'd0, 6'd0, 16'h0005, 16'h0005, 8'h00, 0, 0);
    run_txn("BGZ", 4'd2, 6'd0, 16'hFFFF, 16'h0003, 8'h00, 0, 0);
    run_txn("BLZ", 4'd3, 6'd0, 16'hFFFF, 16'h0003, 8'h00, 0, 0);
    run_txn("BGZpos", 4'd2, 6'd0, 16'h0001, 16'h0003, 8'h00, 0, 0);
  endtask

  task automatic test_backpressure();
    run_txn("HOLD", 4'd15, 6'd3, 16'hA0A0, 16'h0505, 8'h00, 0, 5);
  endtask

  task automatic test_illegal_and_clr();
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    modelSticky = 0;
    checks++;
    if (ovf_sticky !== 1'b0) begin errors++; $display("[TB] FAIL clr_idle ovf_sticky: got %b expected 0", ovf_sticky); end
    run_txn("ILL9", 4'd9, 6'd0, 16'hBEEF, 16'h1234, 8'h77, 0, 0);
    run_txn("ILLfn", 4'd15, 6'd8, 16'hBEEF, 16'h1234, 8'h77, 0, 0);
    run_txn("SUBclr", 4'd15, 6'd1, 16'h8000, 16'h0001, 8'h00, 1, 0);
  endtask

  task automatic test_reset_in_exec();
    req_opcode = 4'd15; req_func = 6'd0; req_rs = 16'h7FFF; req_rt = 16'h7FFF; req_imm = 8'h00;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    modelCount = 0; modelSticky = 0;
    check_reset_values("rst_exec");
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_exec rsp_valid_late: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_random();
    logic [3:0] opc;
    logic [5:0] fn;
    for (int n = 0; n < 60; n++) begin
      opc = 4'($urandom_range(0, 15));
      fn  = 6'($urandom_range(0, 9));
      run_txn("RAND", opc, fn, 16'($urandom), 16'($urandom), 8'($urandom),
              bit'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_immediates();
    test_branches();
    test_backpressure();
    test_illegal_and_clr();
    test_reset_in_exec();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the 16-bit ALU interface (A, B, OP in; C, Cout, bcond out).
- Accepts one decoded TSC instruction per transaction over a valid/ready handshake, then maps opcode/func to a 4-bit ALU OP and selects operands.
- Drives the combinational ALU for exactly one cycle, captures C/Cout/bcond, and returns result, overflow and branch-taken over a second valid/ready handshake.
- Sits between the decode stage and the ALU in the multicycle datapath.

Parameters:
- WIDTH, 16, datapath width; must equal the ALU width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_opcode  in  4  TSC opcode.
- req_func  in  6  TSC func field; used only when opcode = 15.
- req_rs  in  WIDTH  rs register data.
- req_rt  in  WIDTH  rt register data.
- req_imm  in  8  immediate field.
- alu_A  out  WIDTH  ALU operand A (registered).
- alu_B  out  WIDTH  ALU operand B (registered).
- alu_OP  out  4  ALU opcode (registered).
- alu_C  in  WIDTH  ALU result.
- alu_Cout  in  1  ALU signed-overflow flag.
- alu_bcond  in  1  ALU compare flag; 1 when A-B is nonzero under SUB.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  captured ALU result.
- rsp_ovf  out  1  captured Cout; forced 0 for non-add/sub ops.
- rsp_taken  out  1  branch outcome; 0 for non-branch ops.
- rsp_illegal  out  1  opcode/func not supported.
- ovf_sticky  out  1  set by any response with rsp_ovf=1.
- clr_ovf  in  1  clears ovf_sticky.
- op_count  out  CNT_W  number of completed (handed-off) responses.

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready=1; rsp_valid=0.
  - rsp_data=0, rsp_ovf=0, rsp_taken=0, rsp_illegal=0.
  - alu_A=0, alu_B=0, alu_OP=4'b1000 (pass A).
  - ovf_sticky=0; op_count=0.
- A reset asserted in any state aborts the in-flight operation with no response.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: req_ready=1. When req_valid=1, latch the mapping onto alu_A/B/OP and go to EXEC.
  - EXEC: req_ready=0. The ALU settles during this cycle. At the edge, capture alu_C into rsp_data, plus the derived ovf, taken and illegal flags; go to RESP.
  - RESP: rsp_valid=1 and all rsp_* outputs held stable. When rsp_ready=1, go to IDLE and increment op_count (wraps modulo 2^CNT_W).
  - No back-to-back accept: req_ready is 0 in EXEC and RESP.
  - Latency: accept edge N, rsp_valid first high in cycle N+2; minimum 3 cycles per op.
- R-type mapping (opcode 15):
  - A = rs for all entries below; B = rt where a second operand is used.
  - func 0 ADD -> OP 0000, B=rt.
  - func 1 SUB -> OP 0001, B=rt.
  - func 2 AND -> OP 0101, B=rt.
  - func 3 ORR -> OP 0110, B=rt.
  - func 4 NOT -> OP 1001.
  - func 5 TCP -> OP 1100.
  - func 6 SHL -> OP 1101.
  - func 7 SHR -> OP 1011 (arithmetic).
- I-type mapping (A = rs unless noted):
  - opcode 4 ADI -> OP 0000, B = sign-extended imm.
  - opcode 5 ORI -> OP 0110, B = zero-extended imm.
  - opcode 6 LHI -> OP 1111, B = zero-extended imm; result = {imm, 8'h00}.
- Branches (all OP 0001, A=rs):
  - opcode 0 BNE: B=rt; taken = bcond.
  - opcode 1 BEQ: B=rt; taken = ~bcond.
  - opcode 2 BGZ: B=0; taken = bcond & ~C[15].
  - opcode 3 BLZ: B=0; taken = C[15].
  - rsp_data = the subtraction result.
- rsp_ovf = Cout for ADD, SUB, ADI and branches; 0 otherwise.
- Illegal (any other opcode, or func >= 8 with opcode 15):
  - OP=1000, A=0, B=0.
  - Still traverses EXEC/RESP.
  - rsp_illegal=1; rsp_data=0; rsp_ovf=0; rsp_taken=0.
- ovf_sticky:
  - Set at the EXEC->RESP edge when captured ovf=1.
  - Cleared by clr_ovf otherwise.
  - Simultaneous set and clear: set wins.
- alu_A/B/OP hold their last values outside EXEC; they change only on accept.

Decomposition:
- Package alu_pkg holds:
  - ALU OP localparams (ALU_ADD ... ALU_LHI).
  - TSC opcode and func constants.
  - FSM state encoding.
- Sub-module alu_op_decode: purely combinational; maps (opcode, func, rs, rt, imm) to (A, B, OP, is_branch, br_kind, ovf_en, illegal).
- alu_issue_ctrl holds the FSM, capture registers, sticky flag and counter, and instantiates alu_op_decode.

Test Plan:
- ADD: rs=16'h7FFF, rt=1 with rsp_ready=1 -> alu_OP=0000; rsp_data=16'h8000, rsp_ovf=1 at accept+2; ovf_sticky=1; op_count=1.
- ADI: rs=16'h0010, imm=8'hFE -> B=16'hFFFE; rsp_data=16'h000E; rsp_ovf=0.
- LHI: imm=8'hA5 -> rsp_data=16'hA500. ORI: rs=16'h1200, imm=8'h80 -> rsp_data=16'h1280.
- Branches with rs=5, rt=5 -> BEQ taken=1, BNE taken=0. BGZ rs=16'hFFFF -> taken=0. BLZ rs=16'hFFFF -> taken=1.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, op_count unchanged; then rsp_ready=1 -> op_count+1, req_ready=1 next cycle.
- Illegal opcode 9, then clr_ovf asserted coincident with an overflowing SUB (rs=16'h8000, rt=1) -> rsp_illegal=1 with data 0; ovf_sticky stays 1. Reset in EXEC -> no rsp_valid, all outputs at reset values.
